alu_rr_arbiter: RTL

- Shares one ALU between NUM_REQ requesters using round-robin arbitration.
- Accepts at most one operation per cycle and drives the ALU input ports, including CE.
- Tracks in-flight operations with a tag pipeline and returns each result and its flags tagged with the requester ID.
- Sits between the requester-side transaction logic and the ALU DUT pins.

---
 rtl/alu_arb_pkg.sv | 45 ++++
 rtl/alu_rr_picker.sv | 36 +++
 rtl/alu_rr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared widths, flag layout and transaction structs for the ALU round-robin arbiter.
// DATA_WIDTH / CMD_WIDTH are the alu_defines macros; defaults below apply when not predefined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

package alu_arb_pkg;

   localparam int DATA_W   = `DATA_WIDTH;
   localparam int CMD_W    = `CMD_WIDTH;
   localparam int RES_W    = 2 * DATA_W;
   localparam int MAX_REQ  = 8;
   localparam int MAX_ID_W = 3;

   localparam int FLAG_W     = 6;
   localparam int FLAG_ERR   = 5;
   localparam int FLAG_OFLOW = 4;
   localparam int FLAG_COUT  = 3;
   localparam int FLAG_G     = 2;
   localparam int FLAG_L     = 1;
   localparam int FLAG_E     = 0;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic [DATA_W-1:0] opa;
      logic [DATA_W-1:0] opb;
      logic [CMD_W-1:0]  cmd;
      logic              mode;
      logic              cin;
      logic [1:0]        inp_valid;
   } alu_req_t;

   typedef struct packed {
      logic [MAX_ID_W-1:0] id;
      logic [RES_W-1:0]    res;
      logic [FLAG_W-1:0]   flags;
   } alu_rsp_t;

endpackage

// File: rtl/alu_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is zero when no request is asserted.
module alu_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               any
);

   always_comb begin
      int              idx;
      logic [ID_W-1:0] sel;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr < NUM_REQ always holds, so one subtraction is enough to wrap
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = ID_W'(idx);
         if (!any && req[sel]) begin
            any          = 1'b1;
            gnt[sel]     = 1'b1;
            gnt_idx      = sel;
         end
      end
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between NUM_REQ requesters round-robin; optional grant stats under ALU_ARB_STATS_EN.
// Latency: issue regs load on the transfer edge; response registered ALU_LATENCY+1 edges later.
// Backpressure: REQ_READY one-hot per cycle; no response backpressure, every RSP_VALID must be taken.
module alu_rr_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = DATA_W,
   parameter int CMD_WIDTH   = CMD_W,
   parameter int ALU_LATENCY = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              REQ_VALID,
   output logic [NUM_REQ-1:0]              REQ_READY,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_OPA,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_OPB,
   input  logic [NUM_REQ*CMD_WIDTH-1:0]    REQ_CMD,
   input  logic [NUM_REQ-1:0]              REQ_MODE,
   input  logic [NUM_REQ-1:0]              REQ_CIN,
   input  logic [NUM_REQ*2-1:0]            REQ_INP_VALID,
   output logic [DATA_WIDTH-1:0]           OPA,
   output logic [DATA_WIDTH-1:0]           OPB,
   output logic [CMD_WIDTH-1:0]            CMD,
   output logic                            MODE,
   output logic                            CIN,
   output logic                            CE,
   output logic [1:0]                      INP_VALID,
   input  logic [2*DATA_WIDTH-1:0]         RES,
   input  logic                            ERR,
   input  logic                            OFLOW,
   input  logic                            COUT,
   input  logic                            G,
   input  logic                            L,
   input  logic                            E,
`ifdef ALU_ARB_STATS_EN
   input  logic [id_width(NUM_REQ)-1:0]    STAT_SEL,
   output logic [15:0]                     STAT_CNT,
`endif
   output logic                            RSP_VALID,
   output logic [id_width(NUM_REQ)-1:0]    RSP_ID,
   output logic [2*DATA_WIDTH-1:0]         RSP_RES,
   output logic [FLAG_W-1:0]               RSP_FLAGS
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int DEPTH = ALU_LATENCY + 1;

   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic               any;
   logic               xfer;

   alu_req_t           sel_req;
   alu_req_t           iss_q;
   logic               ce_q;

   logic [DEPTH-1:0]   tag_vld;
   logic [ID_W-1:0]    tag_id [DEPTH];

   alu_rsp_t           rsp_q;
   logic               rsp_vld_q;
   logic [FLAG_W-1:0]  alu_flags;
   logic               unused_rsp_id;

   alu_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req     (REQ_VALID),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   // A grant is only a transfer outside reset; ready is masked the same way.
   assign REQ_READY = reset ? '0 : gnt;
   assign xfer      = any & ~reset;

   always_comb begin
      sel_req           = '0;
      sel_req.opa       = REQ_OPA[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      sel_req.opb       = REQ_OPB[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      sel_req.cmd       = REQ_CMD[gnt_idx*CMD_WIDTH +: CMD_WIDTH];
      sel_req.mode      = REQ_MODE[gnt_idx];
      sel_req.cin       = REQ_CIN[gnt_idx];
      sel_req.inp_valid = REQ_INP_VALID[gnt_idx*2 +: 2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Operands and command hold on idle cycles; only CE and INP_VALID drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         iss_q <= '0;
         ce_q  <= 1'b0;
      end else if (xfer) begin
         iss_q <= sel_req;
         ce_q  <= 1'b1;
      end else begin
         iss_q.inp_valid <= 2'b00;
         ce_q            <= 1'b0;
      end
   end

   assign OPA       = iss_q.opa;
   assign OPB       = iss_q.opb;
   assign CMD       = iss_q.cmd;
   assign MODE      = iss_q.mode;
   assign CIN       = iss_q.cin;
   assign INP_VALID = iss_q.inp_valid;
   assign CE        = ce_q;

   // Stage k holds the op transferred k edges ago; the last stage lines up with valid ALU outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_vld <= '0;
         for (int s = 0; s < DEPTH; s++) tag_id[s] <= '0;
      end else begin
         tag_vld[0] <= xfer;
         tag_id[0]  <= gnt_idx;
         for (int s = 1; s < DEPTH; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
      end
   end

   always_comb begin
      alu_flags             = '0;
      alu_flags[FLAG_ERR]   = ERR;
      alu_flags[FLAG_OFLOW] = OFLOW;
      alu_flags[FLAG_COUT]  = COUT;
      alu_flags[FLAG_G]     = G;
      alu_flags[FLAG_L]     = L;
      alu_flags[FLAG_E]     = E;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_vld_q <= 1'b0;
         rsp_q     <= '0;
      end else begin
         rsp_vld_q <= tag_vld[DEPTH-1];
         if (tag_vld[DEPTH-1]) begin
            rsp_q.id    <= MAX_ID_W'(tag_id[DEPTH-1]);
            rsp_q.res   <= RES;
            rsp_q.flags <= alu_flags;
         end
      end
   end

   assign RSP_VALID     = rsp_vld_q;
   assign RSP_ID        = rsp_q.id[ID_W-1:0];
   assign RSP_RES       = rsp_q.res;
   assign RSP_FLAGS     = rsp_q.flags;
   assign unused_rsp_id = ^rsp_q.id;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_cnt [NUM_REQ];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      end else if (xfer && grant_cnt[gnt_idx] != 16'hFFFF) begin
         grant_cnt[gnt_idx] <= grant_cnt[gnt_idx] + 16'd1;
      end
   end

   assign STAT_CNT = (int'(STAT_SEL) < NUM_REQ) ? grant_cnt[STAT_SEL] : 16'h0000;
`endif

endmodule
